// File: rtl/ex_mem_buffer.sv
// EX->MEM pipeline buffer with a valid/ready handshake and EX->EX forwarding taps.
// Define EX_MEM_SKID_EN to add a skid entry and make ex_ready registered.
module ex_mem_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_wb_en,
  input  logic [REG_W-1:0]  ex_wb_addr,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [ADDR_W-1:0] mem_pc,
  output logic              mem_wb_en,
  output logic [REG_W-1:0]  mem_wb_addr,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_pending
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [ADDR_W-1:0] pc;
    logic              wb_en;
    logic [REG_W-1:0]  wb_addr;
    logic              mem_rd;
    logic              mem_wr;
  } entry_t;

  // Encoding doubles as the valid bits: bit0 = OUT valid, bit1 = SKID valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e state_q, state_d;
  entry_t out_q, out_d, in_entry;
  logic   fwd_en_q, fwd_en_d;
  logic   load_pending_q, load_pending_d;
  logic   in_fire, out_fire;

  assign in_entry = {ex_result, ex_store_data, ex_pc, ex_wb_en, ex_wb_addr, ex_mem_rd, ex_mem_wr};
  assign in_fire  = ex_valid & ex_ready;
  assign out_fire = state_q[0] & mem_ready;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q, skid_d;
  logic   ex_ready_q, ex_ready_d;
  assign ex_ready = ex_ready_q;
`else
  assign ex_ready = ~state_q[0] | mem_ready;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef EX_MEM_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            out_d   = in_entry;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            out_d = in_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
`ifdef EX_MEM_SKID_EN
            state_d = FULL;
            skid_d  = in_entry;
`endif
          end
        end
`ifdef EX_MEM_SKID_EN
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            out_d   = skid_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end

`ifdef EX_MEM_SKID_EN
    ex_ready_d = (state_d != FULL);
`endif
    // Side-band outputs are precomputed from next-state OUT so they leave from flops.
    fwd_en_d       = state_d[0] & out_d.wb_en & ~out_d.mem_rd & (out_d.wb_addr != '0);
    load_pending_d = state_d[0] & out_d.wb_en & out_d.mem_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= EMPTY;
      out_q          <= '0;
      fwd_en_q       <= 1'b0;
      load_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_q          <= out_d;
      fwd_en_q       <= fwd_en_d;
      load_pending_q <= load_pending_d;
    end
  end

`ifdef EX_MEM_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      ex_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      ex_ready_q <= ex_ready_d;
    end
  end
`endif

  assign mem_valid      = state_q[0];
  assign mem_result     = out_q.result;
  assign mem_store_data = out_q.store_data;
  assign mem_pc         = out_q.pc;
  assign mem_wb_en      = out_q.wb_en;
  assign mem_wb_addr    = out_q.wb_addr;
  assign mem_mem_rd     = out_q.mem_rd;
  assign mem_mem_wr     = out_q.mem_wr;
  assign fwd_en         = fwd_en_q;
  assign fwd_addr       = out_q.wb_addr;
  assign fwd_data       = out_q.result;
  assign load_pending   = load_pending_q;

endmodule
